// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D cache-line arbiter in front of physical_memory.
// Optional round-robin contention handling is enabled by CACHELINE_ARB_ROUND_ROBIN_EN.
package cacheline_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_A,
        ARB_SERVE_B
    } arb_state_t;

    typedef enum logic {
        ARB_OP_READ,
        ARB_OP_WRITE
    } arb_op_t;

    typedef enum logic {
        ARB_PORT_A,
        ARB_PORT_B
    } arb_port_t;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the two cache miss ports and the physical memory port.
// slave = arbiter view, master = requesters/memory view.
interface cacheline_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              read_a;
    logic [ADDR_W-1:0] address_a;
    logic              resp_a;
    logic [LINE_W-1:0] rdata_a;
    logic              read_b;
    logic              write_b;
    logic [ADDR_W-1:0] address_b;
    logic [LINE_W-1:0] wdata_b;
    logic              resp_b;
    logic [LINE_W-1:0] rdata_b;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic              resp;
    logic [LINE_W-1:0] rdata;

    // Requests are levels held until the matching resp_x pulse; resp_x is a
    // one-cycle completion that coincides with the memory resp cycle.
    modport slave (
        input  read_a, address_a, read_b, write_b, address_b, wdata_b, resp, rdata,
        output resp_a, rdata_a, resp_b, rdata_b, read, write, address, wdata
    );

    modport master (
        output read_a, address_a, read_b, write_b, address_b, wdata_b, resp, rdata,
        input  resp_a, rdata_a, resp_b, rdata_b, read, write, address, wdata
    );
endinterface

// File: rtl/cacheline_arbiter_select.sv
// Combinational winner pick between the two cache ports.
// Fixed B-over-A priority unless CACHELINE_ARB_ROUND_ROBIN_EN is defined.
module cacheline_arb_select
    import cacheline_arb_pkg::*;
(
    input  logic      i_pending_a,
    input  logic      i_pending_b,
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
    input  arb_port_t i_last_grant,
`endif
    output logic      o_grant_valid,
    output arb_port_t o_grant
);
    always_comb begin
        o_grant_valid = i_pending_a | i_pending_b;
        o_grant       = ARB_PORT_A;
        if (i_pending_a && i_pending_b) begin
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
            o_grant = (i_last_grant == ARB_PORT_A) ? ARB_PORT_B : ARB_PORT_A;
`else
            o_grant = ARB_PORT_B;
`endif
        end else if (i_pending_b) begin
            o_grant = ARB_PORT_B;
        end
    end
endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one 256-bit memory port between the I-cache (A) and D-cache (B).
// Build option: CACHELINE_ARB_ROUND_ROBIN_EN selects round-robin on contention.
module cacheline_arbiter
    import cacheline_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cacheline_arbiter_if.slave   bus,
    output arb_state_t           o_dbg_state
);
    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_op_t           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              w_pending_a;
    logic              w_pending_b;
    logic              w_grant_valid;
    arb_port_t         w_grant;

    assign w_pending_a = bus.read_a;
    assign w_pending_b = bus.read_b | bus.write_b;
    assign o_dbg_state = r_state;

`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
    arb_port_t r_last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ARB_PORT_A;
        end else if (r_state == ARB_IDLE && w_grant_valid) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    cacheline_arb_select u_select (
        .i_pending_a   (w_pending_a),
        .i_pending_b   (w_pending_b),
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
        .i_last_grant  (r_last_grant),
`endif
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_op    <= ARB_OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            // Capture the winner so memory sees a stable transaction even if it drops.
            if (r_state == ARB_IDLE && w_grant_valid) begin
                if (w_grant == ARB_PORT_B) begin
                    r_op    <= bus.write_b ? ARB_OP_WRITE : ARB_OP_READ;
                    r_addr  <= bus.address_b;
                    r_wdata <= bus.wdata_b;
                end else begin
                    r_op    <= ARB_OP_READ;
                    r_addr  <= bus.address_a;
                    r_wdata <= '0;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.address  = r_addr;
        bus.wdata    = r_wdata;
        bus.resp_a   = 1'b0;
        bus.resp_b   = 1'b0;
        bus.rdata_a  = '0;
        bus.rdata_b  = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = (w_grant == ARB_PORT_B) ? ARB_SERVE_B : ARB_SERVE_A;
                end
            end
            ARB_SERVE_A: begin
                bus.read  = (r_op == ARB_OP_READ);
                bus.write = (r_op == ARB_OP_WRITE);
                if (bus.resp) begin
                    bus.resp_a   = 1'b1;
                    bus.rdata_a  = bus.rdata;
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_SERVE_B: begin
                bus.read  = (r_op == ARB_OP_READ);
                bus.write = (r_op == ARB_OP_WRITE);
                if (bus.resp) begin
                    bus.resp_b   = 1'b1;
                    bus.rdata_b  = bus.rdata;
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    a_b_read_write_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.read_b && bus.write_b)
    );
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: the bench plays both caches and memory.
module tb_cacheline_arbiter;
    import cacheline_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    arb_state_t dbg_state;
    int         n_pass;
    int         n_total;
    logic       lg;
    logic [4:0] seq;

    localparam logic [255:0] LINE_AA = {32{8'hAA}};
    localparam logic [255:0] LINE_W1 = {8{32'h12345678}};
    localparam logic [255:0] LINE_55 = {32{8'h55}};

    cacheline_arbiter_if bus ();

    cacheline_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    function automatic logic contention_winner();
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
        return (lg == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        lg    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Memory side of one transaction: wait for the strobe, hold it dly cycles,
    // answer with rd, then confirm the mandatory idle cycle.
    task automatic serve(input logic is_b, input logic is_wr, input logic [31:0] a,
                         input logic [255:0] wd, input logic [255:0] rd,
                         input int dly, input logic drop);
        int n;
        n = 0;
        while (!(bus.read || bus.write) && n < 10) begin
            tick();
            n++;
        end
        chk("strobe_wait", 256'(n < 10), 256'(1));
        chk("serve_state", 256'(dbg_state), is_b ? 256'(ARB_SERVE_B) : 256'(ARB_SERVE_A));
        for (int i = 0; i < dly; i++) begin
            chk("hold_read", 256'(bus.read), 256'(!is_wr));
            chk("hold_write", 256'(bus.write), 256'(is_wr));
            chk("hold_addr", 256'(bus.address), 256'(a));
            if (is_wr) chk("hold_wdata", bus.wdata, wd);
            tick();
        end
        bus.resp  = 1'b1;
        bus.rdata = rd;
        if (drop) begin
            if (is_b) begin
                bus.read_b  = 1'b0;
                bus.write_b = 1'b0;
            end else begin
                bus.read_a = 1'b0;
            end
        end
        #1;
        chk("resp_a", 256'(bus.resp_a), 256'(!is_b));
        chk("resp_b", 256'(bus.resp_b), 256'(is_b));
        chk("resp_addr", 256'(bus.address), 256'(a));
        if (is_b) chk("rdata_b", bus.rdata_b, rd);
        else      chk("rdata_a", bus.rdata_a, rd);
        tick();
        bus.resp  = 1'b0;
        bus.rdata = '0;
        #1;
        chk("idle_state", 256'(dbg_state), 256'(ARB_IDLE));
        chk("idle_strobes", 256'({bus.read, bus.write}), 256'(0));
        chk("idle_resps", 256'({bus.resp_a, bus.resp_b}), 256'(0));
        lg = is_b;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        seq         = '0;
        bus.read_a    = 1'b0;
        bus.address_a = '0;
        bus.read_b    = 1'b0;
        bus.write_b   = 1'b0;
        bus.address_b = '0;
        bus.wdata_b   = '0;
        bus.resp      = 1'b0;
        bus.rdata     = '0;

        // Reset values
        rst_n = 1'b0;
        lg    = 1'b0;
        #12;
        chk("rst_state", 256'(dbg_state), 256'(ARB_IDLE));
        chk("rst_strobes", 256'({bus.read, bus.write}), 256'(0));
        chk("rst_resps", 256'({bus.resp_a, bus.resp_b}), 256'(0));
        chk("rst_address", 256'(bus.address), 256'(0));
        chk("rst_wdata", bus.wdata, 256'(0));
        chk("rst_rdata_a", bus.rdata_a, 256'(0));
        chk("rst_rdata_b", bus.rdata_b, 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 256'(dbg_state), 256'(ARB_IDLE));

        // 1: single read on A, memory answers after 4 cycles
        bus.read_a    = 1'b1;
        bus.address_a = 32'h0000_0060;
        serve(1'b0, 1'b0, 32'h60, '0, LINE_AA, 4, 1'b1);

        // 2: single write on B
        bus.write_b   = 1'b1;
        bus.address_b = 32'h0000_0100;
        bus.wdata_b   = LINE_W1;
        serve(1'b1, 1'b1, 32'h100, LINE_W1, '0, 3, 1'b1);
        bus.wdata_b   = '0;

        // 3: simultaneous reads, winner first then loser after one idle cycle
        bus.read_a    = 1'b1;
        bus.address_a = 32'h0000_0020;
        bus.read_b    = 1'b1;
        bus.address_b = 32'h0000_0040;
        if (contention_winner()) begin
            serve(1'b1, 1'b0, 32'h40, '0, LINE_55, 2, 1'b1);
            serve(1'b0, 1'b0, 32'h20, '0, LINE_AA, 2, 1'b1);
        end else begin
            serve(1'b0, 1'b0, 32'h20, '0, LINE_AA, 2, 1'b1);
            serve(1'b1, 1'b0, 32'h40, '0, LINE_55, 2, 1'b1);
        end

`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
        // 4: both ports keep requesting; grants alternate starting with B
        do_reset();
        bus.read_a    = 1'b1;
        bus.address_a = 32'h0000_0200;
        bus.read_b    = 1'b1;
        bus.address_b = 32'h0000_0240;
        for (int k = 0; k < 5; k++) begin
            logic w;
            w = contention_winner();
            if (k == 4) w = 1'b1;
            seq[k] = w;
            serve(w, 1'b0, w ? 32'h240 : 32'h200, '0, LINE_55, 1, k >= 3);
        end
        chk("rr_order", 256'(seq), 256'(5'b10101));
`endif

        // 5: A drops its request mid-transaction while B queues behind it
        bus.read_a    = 1'b1;
        bus.address_a = 32'h0000_0300;
        tick();
        chk("abort_grant", 256'(dbg_state), 256'(ARB_SERVE_A));
        tick();
        tick();
        bus.read_a    = 1'b0;
        bus.read_b    = 1'b1;
        bus.address_b = 32'h0000_0340;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_read", 256'(bus.read), 256'(1));
            chk("abort_addr", 256'(bus.address), 256'(32'h300));
            chk("abort_state", 256'(dbg_state), 256'(ARB_SERVE_A));
        end
        serve(1'b0, 1'b0, 32'h300, '0, LINE_AA, 0, 1'b0);
        serve(1'b1, 1'b0, 32'h340, '0, LINE_55, 2, 1'b1);

        // 6: reset in the middle of a B transaction
        bus.read_b    = 1'b1;
        bus.address_b = 32'h0000_0500;
        tick();
        chk("rst6_state", 256'(dbg_state), 256'(ARB_SERVE_B));
        chk("rst6_read", 256'(bus.read), 256'(1));
        #3;
        rst_n      = 1'b0;
        bus.read_b = 1'b0;
        lg         = 1'b0;
        #1;
        chk("rst6_strobes", 256'({bus.read, bus.write}), 256'(0));
        chk("rst6_resps", 256'({bus.resp_a, bus.resp_b}), 256'(0));
        chk("rst6_idle", 256'(dbg_state), 256'(ARB_IDLE));
        @(negedge clk);
        rst_n         = 1'b1;
        bus.read_a    = 1'b1;
        bus.address_a = 32'h0000_0600;
        serve(1'b0, 1'b0, 32'h600, '0, LINE_AA, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
